tconv_tile_sequencer: RTL and testbench
=======================================

TCONV_TILE_SEQUENCER -- requirements
Module: tconv_tile_sequencer

Interface
REQ-001 SHALL have parameter NUM_PE, default 16, meaning PE columns and BRAM banks per array.
REQ-002 SHALL have parameter W_ADDR_W, default 10, meaning weight BRAM address width.
REQ-003 SHALL have parameter I_ADDR_W, default 10, meaning ifmap BRAM address width.
REQ-004 SHALL have parameter SEL_W, default 4, meaning log2(NUM_PE) bank/column select width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle job request.
- cfg_num_taps  in  8  kernel taps per job.
- cfg_num_ifmap  in  I_ADDR_W  ifmap words per tap.
- cfg_w_base  in  W_ADDR_W  weight base address.
- cfg_i_base  in  I_ADDR_W  ifmap base address.
- stall  in  1  output-storage backpressure.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  one-cycle illegal-config pulse.
- w_re  out  NUM_PE  weight read enable, all banks.
- w_addr_rd  out  W_ADDR_W  weight read address, shared by all banks.
- if_re  out  1  ifmap read enable.
- if_addr_rd  out  I_ADDR_W  ifmap read address.
- ifmap_sel  out  SEL_W  ifmap bank mux select.
- en_weight_load  out  NUM_PE  PE weight capture.
- en_ifmap_load  out  NUM_PE  PE ifmap capture.
- en_psum  out  NUM_PE  PE accumulate enable.
- clear_psum  out  NUM_PE  PE psum clear.
- en_output  out  NUM_PE  PE result drain enable.
- done_select  out  SEL_W+1  drained column index.

Function
REQ-006 SHALL implement FSM IDLE, LOAD_W, COMPUTE, DRAIN, FIN.
REQ-007 In IDLE, start=1 SHALL latch all cfg_* inputs and enter LOAD_W, or FIN with err if cfg_num_taps=0 or cfg_num_ifmap=0.
REQ-008 start while busy=1 SHALL be ignored; cfg_* changes mid-job SHALL have no effect.
REQ-009 busy SHALL be 1 in every state except IDLE.
REQ-010 LOAD_W SHALL last 2 cycles: cycle 1 w_re=all-ones, w_addr_rd=w_base+tap; cycle 2 en_weight_load=all-ones (1-cycle BRAM latency).
REQ-011 COMPUTE SHALL issue word i (0..N-1) on cycle i: if_re=1, ifmap_sel=i[SEL_W-1:0], if_addr_rd=i_base+(i>>SEL_W).
REQ-012 On cycle i+1, en_ifmap_load and en_psum SHALL be all-ones; clear_psum SHALL be all-ones only for i=0.
REQ-013 COMPUTE SHALL therefore last N+1 cycles, the last cycle being a tail with if_re=0.
REQ-014 DRAIN SHALL step done_select 0..NUM_PE-1 with en_output=all-ones, one column per non-stalled cycle.
REQ-015 While stall=1 in DRAIN, the column counter SHALL hold and en_output SHALL be 0; stall SHALL be ignored in other states.
REQ-016 After column NUM_PE-1, the FSM SHALL go to LOAD_W with tap+1 if tap+1<cfg_num_taps, else to FIN.
REQ-017 FIN SHALL last 1 cycle, pulse done (or err for an illegal config, never both), then return to IDLE.
REQ-018 With no stall, done SHALL assert exactly T*(N+NUM_PE+3)+1 cycles after the start cycle.
REQ-019 Address sums SHALL wrap modulo 2^W_ADDR_W and 2^I_ADDR_W without flagging.
REQ-020 All control outputs SHALL be registered, and 0 when not driven by the rules above.

Reset
REQ-021 rst=1 SHALL immediately force IDLE and clear all outputs, counters and latched config to 0, including mid-job.
REQ-022 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-023 NUM_PE=16, T=1, N=4, bases 0, no stall -> done at cycle 24; if_addr_rd 0,0,0,0; ifmap_sel 0,1,2,3; done_select 0..15.
REQ-024 T=2, N=20, w_base=1020 -> w_addr_rd 1020 then 1021; second-tap ifmap words 16-19 at if_addr_rd 1, ifmap_sel 0..3; done at cycle 79.
REQ-025 stall=1 for 5 cycles mid-DRAIN -> done_select holds, en_output=0; done delayed by exactly 5 cycles.
REQ-026 start with cfg_num_taps=0 -> err pulse 1 cycle later, done never asserts, back to IDLE after 2 cycles.
REQ-027 rst pulse during COMPUTE -> all outputs 0 in the same cycle; a new start after release runs to normal completion.
REQ-028 start re-asserted while busy -> no restart; done count and timing unchanged.

Source files
------------

// File: rtl/tconv_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tconv_tile_sequencer
// Sequences one transposed-convolution tile job over a NUM_PE-wide PE array:
// per kernel tap it loads weights from all weight banks, streams the ifmap
// words through the array, then drains the NUM_PE accumulated columns.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   start                 one-cycle job request, sampled only in IDLE
//   cfg_num_taps/ifmap    taps per job / ifmap words per tap (latched)
//   cfg_w_base/i_base     weight / ifmap base addresses (latched)
//   stall                 drain backpressure, honoured only in DRAIN
//   busy, done, err       status; done/err are one-cycle pulses in FIN
//   w_re, w_addr_rd       weight bank reads
//   if_re, if_addr_rd     ifmap reads, ifmap_sel picks the ifmap bank
//   en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output
//                         per-column PE controls
//   done_select           column currently being drained
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD_W  | phase 0: weight read issued, phase 1: PEs capture weights
// S_COMPUTE | word idx issued; previous word captured/accumulated; idx==N is tail
// S_DRAIN   | one column out per non-stalled cycle
// S_FIN     | one cycle with done or err, then back to IDLE
//
// All outputs are flops. The next-state logic also computes the outputs for
// the cycle being entered, so each output lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module tconv_tile_sequencer #(
   parameter int NUM_PE   = 16,
   parameter int W_ADDR_W = 10,
   parameter int I_ADDR_W = 10,
   parameter int SEL_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [7:0]          cfg_num_taps,
   input  logic [I_ADDR_W-1:0] cfg_num_ifmap,
   input  logic [W_ADDR_W-1:0] cfg_w_base,
   input  logic [I_ADDR_W-1:0] cfg_i_base,
   input  logic                stall,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [NUM_PE-1:0]   w_re,
   output logic [W_ADDR_W-1:0] w_addr_rd,
   output logic                if_re,
   output logic [I_ADDR_W-1:0] if_addr_rd,
   output logic [SEL_W-1:0]    ifmap_sel,
   output logic [NUM_PE-1:0]   en_weight_load,
   output logic [NUM_PE-1:0]   en_ifmap_load,
   output logic [NUM_PE-1:0]   en_psum,
   output logic [NUM_PE-1:0]   clear_psum,
   output logic [NUM_PE-1:0]   en_output,
   output logic [SEL_W:0]      done_select
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN, S_FIN} state_t;

   localparam logic [I_ADDR_W-1:0] I_ONE    = I_ADDR_W'(1);
   localparam logic [SEL_W:0]      COL_ONE  = (SEL_W+1)'(1);
   localparam logic [SEL_W:0]      COL_DONE = (SEL_W+1)'(NUM_PE);

   state_t              state, nxt_state;
   logic [7:0]          taps_q, nxt_taps, tap_q, nxt_tap;
   logic [I_ADDR_W-1:0] n_q, nxt_n, i_base_q, nxt_i_base, idx_q, nxt_idx;
   logic [W_ADDR_W-1:0] w_base_q, nxt_w_base;
   logic                ld_phase_q, nxt_ld_phase;
   logic [SEL_W:0]      col_q, nxt_col;

   logic                busy_d, done_d, err_d, if_re_d;
   logic [NUM_PE-1:0]   w_re_d, en_wl_d, en_ifl_d, en_psum_d, clear_d, en_out_d;
   logic [W_ADDR_W-1:0] w_addr_d;
   logic [I_ADDR_W-1:0] if_addr_d;
   logic [SEL_W-1:0]    sel_d;
   logic [SEL_W:0]      dsel_d;

   always_comb begin
      nxt_state    = state;
      nxt_taps     = taps_q;
      nxt_n        = n_q;
      nxt_w_base   = w_base_q;
      nxt_i_base   = i_base_q;
      nxt_tap      = tap_q;
      nxt_idx      = idx_q;
      nxt_ld_phase = ld_phase_q;
      nxt_col      = col_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      w_re_d       = '0;
      w_addr_d     = '0;
      if_re_d      = 1'b0;
      if_addr_d    = '0;
      sel_d        = '0;
      en_wl_d      = '0;
      en_ifl_d     = '0;
      en_psum_d    = '0;
      clear_d      = '0;
      en_out_d     = '0;
      dsel_d       = '0;

      case (state)
         S_IDLE: begin
            if (start) begin
               nxt_taps   = cfg_num_taps;
               nxt_n      = cfg_num_ifmap;
               nxt_w_base = cfg_w_base;
               nxt_i_base = cfg_i_base;
               nxt_tap    = '0;
               if (cfg_num_taps == '0 || cfg_num_ifmap == '0) begin
                  nxt_state = S_FIN;
                  err_d     = 1'b1;
               end else begin
                  nxt_state    = S_LOAD_W;
                  nxt_ld_phase = 1'b0;
                  w_re_d       = '1;
                  w_addr_d     = cfg_w_base;
               end
            end
         end
         S_LOAD_W: begin
            if (!ld_phase_q) begin
               nxt_ld_phase = 1'b1;
               en_wl_d      = '1;
            end else begin
               nxt_state = S_COMPUTE;
               nxt_idx   = '0;
               if_re_d   = 1'b1;
               if_addr_d = i_base_q;
            end
         end
         S_COMPUTE: begin
            if (idx_q == n_q) begin
               nxt_state = S_DRAIN;
               en_out_d  = '1;
               dsel_d    = '0;
               nxt_col   = COL_ONE;
            end else begin
               // word idx_q lands in the PEs next cycle; idx_q==0 opens a fresh psum
               nxt_idx   = idx_q + I_ONE;
               en_ifl_d  = '1;
               en_psum_d = '1;
               if (idx_q == '0) clear_d = '1;
               if (nxt_idx < n_q) begin
                  if_re_d   = 1'b1;
                  sel_d     = nxt_idx[SEL_W-1:0];
                  if_addr_d = i_base_q + (nxt_idx >> SEL_W);
               end
            end
         end
         S_DRAIN: begin
            // col_q counts columns already presented; NUM_PE means drain complete
            if (stall) begin
               dsel_d = done_select;
            end else if (col_q == COL_DONE) begin
               if (({1'b0, tap_q} + 9'd1) < {1'b0, taps_q}) begin
                  nxt_state    = S_LOAD_W;
                  nxt_tap      = tap_q + 8'd1;
                  nxt_ld_phase = 1'b0;
                  w_re_d       = '1;
                  w_addr_d     = w_base_q + W_ADDR_W'(tap_q + 8'd1);
               end else begin
                  nxt_state = S_FIN;
                  done_d    = 1'b1;
               end
            end else begin
               en_out_d = '1;
               dsel_d   = col_q;
               nxt_col  = col_q + COL_ONE;
            end
         end
         S_FIN: begin
            nxt_state = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase

      busy_d = (nxt_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         taps_q         <= '0;
         n_q            <= '0;
         w_base_q       <= '0;
         i_base_q       <= '0;
         tap_q          <= '0;
         idx_q          <= '0;
         ld_phase_q     <= 1'b0;
         col_q          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         w_re           <= '0;
         w_addr_rd      <= '0;
         if_re          <= 1'b0;
         if_addr_rd     <= '0;
         ifmap_sel      <= '0;
         en_weight_load <= '0;
         en_ifmap_load  <= '0;
         en_psum        <= '0;
         clear_psum     <= '0;
         en_output      <= '0;
         done_select    <= '0;
      end else begin
         state          <= nxt_state;
         taps_q         <= nxt_taps;
         n_q            <= nxt_n;
         w_base_q       <= nxt_w_base;
         i_base_q       <= nxt_i_base;
         tap_q          <= nxt_tap;
         idx_q          <= nxt_idx;
         ld_phase_q     <= nxt_ld_phase;
         col_q          <= nxt_col;
         busy           <= busy_d;
         done           <= done_d;
         err            <= err_d;
         w_re           <= w_re_d;
         w_addr_rd      <= w_addr_d;
         if_re          <= if_re_d;
         if_addr_rd     <= if_addr_d;
         ifmap_sel      <= sel_d;
         en_weight_load <= en_wl_d;
         en_ifmap_load  <= en_ifl_d;
         en_psum        <= en_psum_d;
         clear_psum     <= clear_d;
         en_output      <= en_out_d;
         done_select    <= dsel_d;
      end
   end

endmodule

// File: tb/tb_tconv_tile_sequencer.sv
module tb_tconv_tile_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_num_taps;
   logic [9:0]  cfg_num_ifmap;
   logic [9:0]  cfg_w_base;
   logic [9:0]  cfg_i_base;
   logic        stall;
   logic        busy, done, err;
   logic [15:0] w_re;
   logic [9:0]  w_addr_rd;
   logic        if_re;
   logic [9:0]  if_addr_rd;
   logic [3:0]  ifmap_sel;
   logic [15:0] en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output;
   logic [4:0]  done_select;

   tconv_tile_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_num_taps(cfg_num_taps), .cfg_num_ifmap(cfg_num_ifmap),
      .cfg_w_base(cfg_w_base), .cfg_i_base(cfg_i_base), .stall(stall),
      .busy(busy), .done(done), .err(err),
      .w_re(w_re), .w_addr_rd(w_addr_rd), .if_re(if_re), .if_addr_rd(if_addr_rd),
      .ifmap_sel(ifmap_sel), .en_weight_load(en_weight_load),
      .en_ifmap_load(en_ifmap_load), .en_psum(en_psum), .clear_psum(clear_psum),
      .en_output(en_output), .done_select(done_select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy, done, err;
      logic [15:0] w_re;
      logic [9:0]  w_addr;
      logic        if_re;
      logic [9:0]  if_addr;
      logic [3:0]  sel;
      logic [15:0] en_wl, en_ifl, en_psum, clear, en_out;
      logic [4:0]  dsel;
   } obs_t;

   obs_t exp_q[$];
   bit   stall_arr[1024];
   int   model_fin;
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t sample();
      obs_t o;
      o.busy = busy; o.done = done; o.err = err;
      o.w_re = w_re; o.w_addr = w_addr_rd;
      o.if_re = if_re; o.if_addr = if_addr_rd; o.sel = ifmap_sel;
      o.en_wl = en_weight_load; o.en_ifl = en_ifmap_load; o.en_psum = en_psum;
      o.clear = clear_psum; o.en_out = en_output; o.dsel = done_select;
      return o;
   endfunction

   // Reference: expected outputs per cycle, index 0 being the start cycle.
   // A stall seen during a drain cycle turns the following cycle into a hold cycle.
   task automatic build_model(input int t, input int n, input int wb, input int ib);
      obs_t e;
      int   emitted;
      int   last;
      exp_q.delete();
      e = '0;
      exp_q.push_back(e);
      if (t == 0 || n == 0) begin
         e = '0; e.busy = 1'b1; e.err = 1'b1;
         exp_q.push_back(e);
         e = '0;
         exp_q.push_back(e);
         model_fin = -1;
         return;
      end
      for (int tap = 0; tap < t; tap++) begin
         e = '0; e.busy = 1'b1; e.w_re = '1; e.w_addr = 10'((wb + tap) % 1024);
         exp_q.push_back(e);
         e = '0; e.busy = 1'b1; e.en_wl = '1;
         exp_q.push_back(e);
         for (int k = 0; k <= n; k++) begin
            e = '0; e.busy = 1'b1;
            if (k < n) begin
               e.if_re = 1'b1;
               e.sel = 4'(k % 16);
               e.if_addr = 10'((ib + k / 16) % 1024);
            end
            if (k > 0) begin
               e.en_ifl = '1; e.en_psum = '1;
               if (k == 1) e.clear = '1;
            end
            exp_q.push_back(e);
         end
         e = '0; e.busy = 1'b1; e.en_out = '1; e.dsel = 5'd0;
         exp_q.push_back(e);
         emitted = 1;
         last = 0;
         forever begin
            if (stall_arr[exp_q.size() - 1]) begin
               e = '0; e.busy = 1'b1; e.dsel = 5'(last);
               exp_q.push_back(e);
            end else if (emitted == 16) begin
               break;
            end else begin
               e = '0; e.busy = 1'b1; e.en_out = '1; e.dsel = 5'(emitted);
               exp_q.push_back(e);
               last = emitted;
               emitted++;
            end
         end
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
      model_fin = exp_q.size() - 1;
      e = '0;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1. exp_done: cycle of done pulse, -1 = never, 0 = from model.
   task automatic run_job(input string tag, input int t, input int n, input int wb,
                          input int ib, input int exp_done, input bit rnd_start);
      obs_t obs;
      int   done_at;
      int   want_done;
      int   fin;
      build_model(t, n, wb, ib);
      want_done = (exp_done == 0) ? model_fin : exp_done;
      fin = exp_q.size() - 2;
      done_at = -1;
      for (int c = 0; c < exp_q.size(); c++) begin
         if (c == 0) begin
            start = 1'b1;
            cfg_num_taps = 8'(t); cfg_num_ifmap = 10'(n);
            cfg_w_base = 10'(wb); cfg_i_base = 10'(ib);
         end else begin
            @(posedge clk);
            #1;
            start = (rnd_start && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_num_taps = 8'($urandom); cfg_num_ifmap = 10'($urandom);
            cfg_w_base = 10'($urandom); cfg_i_base = 10'($urandom);
         end
         stall = stall_arr[c];
         @(negedge clk);
         obs = sample();
         if (obs.done && done_at < 0) done_at = c;
         checks++;
         assert (obs === exp_q[c]) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp_q[c]);
         end
      end
      start = 1'b0;
      stall = 1'b0;
      checks++;
      assert (done_at === want_done) else begin
         errors++;
         $error("FAIL %s done_cycle observed=%0d expected=%0d", tag, done_at, want_done);
      end
   endtask

   task automatic clear_stall();
      for (int i = 0; i < 1024; i++) stall_arr[i] = 1'b0;
   endtask

   initial begin
      obs_t obs;
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      cfg_num_taps = '0; cfg_num_ifmap = '0; cfg_w_base = '0; cfg_i_base = '0;
      clear_stall();
      repeat (2) @(posedge clk);
      #1;
      obs = sample();
      checks++;
      assert (obs === obs_t'(0)) else begin
         errors++;
         $error("FAIL reset_state observed=%h expected=0", obs);
      end

      // release and start on the very first edge afterwards
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_job("basic_t1_n4", 1, 4, 0, 0, 24, 1'b0);

      @(posedge clk); #1;
      run_job("two_taps_wrap", 2, 20, 1020, 0, 79, 1'b0);

      for (int i = 12; i < 17; i++) stall_arr[i] = 1'b1;
      @(posedge clk); #1;
      run_job("drain_stall5", 1, 4, 0, 0, 29, 1'b0);
      clear_stall();

      @(posedge clk); #1;
      run_job("zero_taps", 0, 5, 3, 7, -1, 1'b0);
      @(posedge clk); #1;
      run_job("zero_ifmap", 3, 0, 3, 7, -1, 1'b0);

      @(posedge clk); #1;
      run_job("start_while_busy", 1, 4, 0, 0, 24, 1'b1);

      // asynchronous reset in the middle of COMPUTE
      @(posedge clk); #1;
      start = 1'b1; cfg_num_taps = 8'd1; cfg_num_ifmap = 10'd30;
      cfg_w_base = 10'd5; cfg_i_base = 10'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      obs = sample();
      checks++;
      assert (obs === obs_t'(0)) else begin
         errors++;
         $error("FAIL rst_mid_compute observed=%h expected=0", obs);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_job("after_reset", 1, 4, 0, 0, 24, 1'b0);

      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 1024; i++) stall_arr[i] = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         run_job("random_job", int'($urandom_range(1, 3)), int'($urandom_range(1, 40)),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 1'b1);
      end
      clear_stall();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
